// File: rtl/conv_pkg.sv
// Shared types, sizes and arithmetic helpers for the 3x3 convolution window MAC.
// The saturation helper maps a signed accumulator onto an unsigned 8-bit pixel.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int KTAPS  = 9;
    localparam int ACC_W  = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Arithmetic shift, then clamp negatives to 0 and anything above the pixel range to all-ones.
    function automatic logic [DATA_W-1:0] sat_u8(input logic signed [ACC_W-1:0] acc,
                                                 input int                      shift);
        logic signed [ACC_W-1:0] r;
        r = acc >>> shift;
        if (r[ACC_W-1]) begin
            sat_u8 = {DATA_W{1'b0}};
        end else if (|r[ACC_W-2:DATA_W]) begin
            sat_u8 = {DATA_W{1'b1}};
        end else begin
            sat_u8 = r[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Circular single-row delay line: dout is the pixel written exactly `width` enables ago.
// The pointer wraps at width-1, so only the first `width` entries are ever used.
module conv_line_buffer #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [$clog2(MAX_W):0]     width,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout
);

    localparam int PTR_W = $clog2(MAX_W);

    logic [DATA_W-1:0] mem_r [MAX_W];
    logic [PTR_W-1:0]  ptr_r;

    // Read-before-write: the slot about to be overwritten holds the pixel from one row back.
    assign dout = mem_r[ptr_r];

    // Storage write; contents need no reset because every slot is rewritten before use.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_r[ptr_r] <= din;
        end
    end

    // Pointer advance with wrap at width-1 (also recovers if it is ever beyond the row).
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (en) begin
            if ({1'b0, ptr_r} >= width - (PTR_W+1)'(1)) begin
                ptr_r <= {PTR_W{1'b0}};
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// 3x3 sliding-window multiply-accumulate over a padded row-major pixel stream,
// with a single-entry valid/ready output register and a frame-level start/done handshake.
module conv_window_mac #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 16,
    parameter int ACC_W  = 21,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        cfg_width,
    input  logic [4:0]        cfg_height,
    input  logic              k_we,
    input  logic [3:0]        k_addr,
    input  logic [DATA_W-1:0] k_data,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    import conv_pkg::*;

    localparam logic [5:0] MAX_W_L = 6'(MAX_W);

    state_t                   state_r;
    logic [4:0]               width_r;
    logic [4:0]               height_r;
    logic [4:0]               row_r;
    logic [4:0]               col_r;
    logic                     cfg_err_r;
    logic                     out_valid_r;
    logic [DATA_W-1:0]        out_data_r;
    logic signed [DATA_W-1:0] kernel_r [KTAPS];
    logic [DATA_W-1:0]        win_r [3][3];
    logic [DATA_W-1:0]        win_s [3][3];
    logic [DATA_W-1:0]        lb1_dout_s;
    logic [DATA_W-1:0]        lb2_dout_s;
    logic signed [ACC_W-1:0]  acc_s;
    logic                     out_free_s;
    logic                     accept_s;
    logic                     complete_s;
    logic                     last_s;
    logic                     cfg_ok_s;
    logic                     start_ok_s;
    logic                     lb_rst_s;

    assign out_free_s = !out_valid_r || out_ready;
    assign in_ready   = (state_r == RUN) && out_free_s;
    assign accept_s   = in_valid && in_ready;
    assign complete_s = accept_s && (row_r >= 5'd2) && (col_r >= 5'd2);
    assign last_s     = (row_r == height_r - 5'd1) && (col_r == width_r - 5'd1);
    assign cfg_ok_s   = (cfg_width >= 5'd3) && ({1'b0, cfg_width} <= MAX_W_L) && (cfg_height >= 5'd3);
    assign start_ok_s = (state_r == IDLE) && start && cfg_ok_s;
    // Line-buffer pointers restart with every frame so the row delay is exactly W.
    assign lb_rst_s   = rst || start_ok_s;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = (state_r != IDLE);
    assign done      = (state_r == DONE);
    assign cfg_err   = cfg_err_r;

    conv_line_buffer #(.DATA_W(DATA_W), .MAX_W(MAX_W)) u_lb1 (
        .clk   (clk),
        .rst   (lb_rst_s),
        .en    (accept_s),
        .width (width_r),
        .din   (in_pixel),
        .dout  (lb1_dout_s)
    );

    conv_line_buffer #(.DATA_W(DATA_W), .MAX_W(MAX_W)) u_lb2 (
        .clk   (clk),
        .rst   (lb_rst_s),
        .en    (accept_s),
        .width (width_r),
        .din   (lb1_dout_s),
        .dout  (lb2_dout_s)
    );

    // Window after this accept: older columns shift left, newest column is (row-2, row-1, row).
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_s[r][0] = win_r[r][1];
            win_s[r][1] = win_r[r][2];
            win_s[r][2] = {DATA_W{1'b0}};
        end
        win_s[0][2] = lb2_dout_s;
        win_s[1][2] = lb1_dout_s;
        win_s[2][2] = in_pixel;
    end

    // Unsigned pixel times signed tap, summed over the nine taps of the next window.
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int t = 0; t < KTAPS; t++) begin
            acc_s = acc_s
                  + ($signed({{(ACC_W-DATA_W){1'b0}}, win_s[t/3][t%3]})
                   * $signed({{(ACC_W-DATA_W){kernel_r[t][DATA_W-1]}}, kernel_r[t]}));
        end
    end

    // Frame control FSM: config latch, row/column counting and the rejected-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            width_r   <= 5'd0;
            height_r  <= 5'd0;
            row_r     <= 5'd0;
            col_r     <= 5'd0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        width_r  <= cfg_width;
                        height_r <= cfg_height;
                        row_r    <= 5'd0;
                        col_r    <= 5'd0;
                        state_r  <= RUN;
                    end else if (start) begin
                        cfg_err_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        if (col_r == width_r - 5'd1) begin
                            col_r <= 5'd0;
                            row_r <= row_r + 5'd1;
                        end else begin
                            col_r <= col_r + 5'd1;
                        end
                        if (last_s) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free_s) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Kernel taps are writable only while idle; addresses past the last tap are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < KTAPS; t++) begin
                kernel_r[t] <= {DATA_W{1'b0}};
            end
        end else if ((state_r == IDLE) && k_we && (k_addr <= 4'd8)) begin
            kernel_r[k_addr] <= k_data;
        end
    end

    // Window shift register advances on every accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_r[r][c] <= {DATA_W{1'b0}};
                end
            end
        end else if (accept_s) begin
            win_r <= win_s;
        end
    end

    // Output register: a completing pixel reloads it even in the cycle the old result leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (complete_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sat_u8(acc_s, SHIFT);
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: expected results are queued as frames are driven
// and compared by a monitor at every output handshake.
module tb_conv_window_mac;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] cfg_width;
    logic [4:0] cfg_height;
    logic       k_we;
    logic [3:0] k_addr;
    logic [7:0] k_data;
    logic       start;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int         checks = 0;
    int         errors = 0;
    int         n_out  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] img [256];
    int         kern [9];
    logic       was_stalled = 1'b0;
    logic [7:0] held_data   = 8'd0;

    always #5 clk = ~clk;

    conv_window_mac #(.DATA_W(8), .MAX_W(16), .ACC_W(21), .SHIFT(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .k_we       (k_we),
        .k_addr     (k_addr),
        .k_data     (k_data),
        .start      (start),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    // Scoreboard monitor: output order, hold-while-stalled and back-pressure on in_ready.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            was_stalled = 1'b0;
        end else begin
            if (was_stalled) begin
                checks++;
                assert (out_valid === 1'b1 && out_data === held_data) else begin
                    errors++;
                    $error("FAIL hold_stable: got valid=%0b data=%0d, expected valid=1 data=%0d",
                           out_valid, out_data, held_data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                checks++;
                assert (in_ready === 1'b0) else begin
                    errors++;
                    $error("FAIL stall_in_ready: got %0b, expected 0", in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_output: got %0d, expected no output", out_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (out_data === e) else begin
                        errors++;
                        $error("FAIL out_data[%0d]: got %0d, expected %0d", n_out, out_data, e);
                    end
                end
                n_out++;
            end
            was_stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
            held_data   = out_data;
        end
    end

    task automatic load_kernel();
        for (int t = 0; t < 9; t++) begin
            k_we   = 1'b1;
            k_addr = t[3:0];
            k_data = kern[t][7:0];
            @(posedge clk); #1;
        end
        k_we = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_width  = w[4:0];
        cfg_height = h[4:0];
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_pixels(input int n, input string tag);
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        while (idx < n && guard < 2000) begin
            in_valid = 1'b1;
            in_pixel = img[idx];
            @(negedge clk);
            if (in_ready === 1'b1) idx++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        chk({tag, "_pixels_accepted"}, idx, n);
    endtask

    // Reference 3x3 convolution over the image array, clamped to 0..255.
    task automatic push_model(input int w, input int h);
        int         acc;
        logic [7:0] v;
        for (int r = 0; r <= h - 3; r++) begin
            for (int c = 0; c <= w - 3; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += int'(img[(r + i) * w + c + j]) * kern[i * 3 + j];
                if (acc < 0)        v = 8'd0;
                else if (acc > 255) v = 8'd255;
                else                v = acc[7:0];
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        chk({tag, "_done_single"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = 8'd0;
        k_we = 1'b0; k_addr = 4'd0; k_data = 8'd0;
        cfg_width = 5'd0; cfg_height = 5'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);

        // Identity kernel over a 4x4 ramp.
        kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_kernel();
        for (int i = 0; i < 16; i++) img[i] = i[7:0];
        exp_q.push_back(8'd5); exp_q.push_back(8'd6);
        exp_q.push_back(8'd9); exp_q.push_back(8'd10);
        n_out = 0;
        start_frame(4, 4);
        chk("ident_busy", busy, 1);
        send_pixels(16, "ident");
        wait_done("ident");
        chk("ident_count", n_out, 4);

        // All-ones kernel over saturated pixels, 5x3.
        kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_kernel();
        for (int i = 0; i < 15; i++) img[i] = 8'd255;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'd255);
        n_out = 0;
        start_frame(5, 3);
        send_pixels(15, "ones");
        wait_done("ones");
        chk("ones_count", n_out, 3);

        // Negative result clamps to zero.
        kern = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
        load_kernel();
        for (int i = 0; i < 16; i++) img[i] = 8'd10;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'd0);
        n_out = 0;
        start_frame(4, 4);
        send_pixels(16, "neg");
        wait_done("neg");
        chk("neg_count", n_out, 4);

        // Mixed kernel, random pixels, out_ready held low for 5 cycles mid-frame.
        kern = '{1, -2, 3, -1, 4, 2, -3, 1, 2};
        load_kernel();
        for (int i = 0; i < 30; i++) img[i] = $urandom_range(0, 255);
        push_model(6, 5);
        n_out = 0;
        start_frame(6, 5);
        fork
            send_pixels(30, "stall");
            begin
                repeat (16) @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done("stall");
        chk("stall_count", n_out, 12);

        // Widest legal row.
        for (int i = 0; i < 48; i++) img[i] = $urandom_range(0, 255);
        push_model(16, 3);
        n_out = 0;
        start_frame(16, 3);
        send_pixels(48, "maxw");
        wait_done("maxw");
        chk("maxw_count", n_out, 14);

        // Rejected configurations: width too small, width too large, height too small.
        start_frame(2, 4);
        @(negedge clk);
        chk("cfg_w2_err", cfg_err, 1);
        chk("cfg_w2_busy", busy, 0);
        @(negedge clk);
        chk("cfg_w2_err_pulse", cfg_err, 0);
        start_frame(17, 4);
        @(negedge clk);
        chk("cfg_w17_err", cfg_err, 1);
        start_frame(4, 2);
        @(negedge clk);
        chk("cfg_h2_err", cfg_err, 1);
        chk("cfg_h2_busy", busy, 0);

        // Reset mid-frame aborts without done or output.
        for (int i = 0; i < 16; i++) img[i] = i[7:0];
        start_frame(4, 4);
        send_pixels(6, "abort");
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);

        // Kernel writes during RUN are ignored.
        kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_kernel();
        for (int i = 0; i < 20; i++) img[i] = $urandom_range(0, 255);
        push_model(5, 4);
        n_out = 0;
        start_frame(5, 4);
        k_we = 1'b1; k_addr = 4'd4; k_data = 8'd3;
        send_pixels(20, "kwe");
        k_we = 1'b0;
        wait_done("kwe");
        chk("kwe_count", n_out, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
